dmni_br_mailbox: RTL
====================

Name: dmni_br_mailbox

Overview:
- Parametrised broadcast-message mailbox for the DMNI.
- Buffers incoming BrLite broadcast messages (ksvc, seq_source, payload) in a circular FIFO. Exposes them to the CPU through the DMNI MMR window at 0x40–0x4C.
- Generalises the fixed single-entry ksvc/payload registers to configurable field widths and depth.
- Adds an overflow policy, drop counter and level-based IRQ.

Parameters:
- PAYLOAD_W, 16, payload field width (PAYLOAD_W + SEQ_W ≤ 32).
- SEQ_W, 16, seq_source field width.
- KSVC_W, 4, kernel-service field width (≤ 8).
- DEPTH, 8, FIFO entries; power of two, ≥ 2.
- DROP_ON_FULL, 1, 1 = accept and discard when full; 0 = backpressure.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- br_req_i  in  1  incoming broadcast valid.
- br_ack_o  out  1  incoming broadcast accepted; transfer occurs when br_req_i & br_ack_o.
- br_ksvc_i  in  KSVC_W  ksvc field.
- br_seq_source_i  in  SEQ_W  sequence/source field.
- br_payload_i  in  PAYLOAD_W  payload field.
- cfg_sel_i  in  1  MMR access strobe, one cycle per access.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_addr_i  in  8  MMR byte address.
- cfg_data_i  in  32  MMR write data.
- cfg_data_o  out  32  MMR read data, registered.
- irq_o  out  1  mailbox interrupt.

Behaviour:
- Reset (rst_ni low, asynchronous) clears all state:
  - Pointers and count to 0.
  - drop_cnt (8 bit) and ovf flag to 0.
  - irq_en to 0.
  - cfg_data_o to 0.
  - irq_o to 0.
  - FIFO storage contents are don't-care.
- br_ack_o is combinational:
  - DROP_ON_FULL = 1: br_ack_o = 1 always.
  - DROP_ON_FULL = 0: br_ack_o = !full.
- Push on br_req_i & br_ack_o:
  - If not full, or if a pop occurs in the same cycle: write the entry at wr_ptr, advance wr_ptr.
  - Else (full, no pop, DROP_ON_FULL = 1): discard the entry, set ovf, increment drop_cnt (saturates at 255).
- MMR map (offsets not listed read 0; writes to them are ignored):
  - 0x40 BR_KSVC, read: {empty, 31−KSVC_W zeros, head.ksvc}. Non-destructive peek.
  - 0x44 BR_PAYLOAD, read: {head.seq_source, head.payload}, zero-extended to 32 with seq_source in the upper field. Destructive: pops the head if not empty. If empty, returns 0 and performs no pop.
  - 0x48 BR_STATUS, read: {ovf[31], 7'b0, drop_cnt[23:16], 8'b0, count[7:0]}. Write of any value clears ovf and drop_cnt.
  - 0x4C BR_IRQ_EN, read/write: bit0 = irq_en.
- Read latency:
  - cfg_data_o updates on the clock edge that samples cfg_sel_i & !cfg_we_i.
  - cfg_data_o holds its value until the next read.
  - A pop takes effect on that same edge.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - When full, the push is accepted, not dropped.
  - When empty, the pop is suppressed and the push proceeds (no bypass).
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, zero-extended into the status field.
- Simultaneous status-clear write and drop in the same cycle: the clear wins; drop_cnt = 0 and ovf = 0.
- irq_o is registered: irq_o = irq_en & (count != 0), evaluated on the next-state count. It deasserts on the edge after the last pop.
- A reset asserted mid-transfer aborts all state immediately. br_ack_o is driven as if empty once rst_ni is released.

Test Plan:
1. Reset, then push {ksvc=3, seq=0x0102, payload=0xBEEF}:
   - Read 0x40 → 0x00000003.
   - Read 0x44 → 0x0102BEEF.
   - Read 0x40 → 0x80000000 (empty).
2. DEPTH=8, DROP_ON_FULL=1, push 11 entries without reading:
   - br_ack_o stays 1.
   - 0x48 reads 0x80030008.
   - Eight 0x44 reads return entries 0–7 in order.
   - Write 0x48 → status reads 0x00000000.
3. DROP_ON_FULL=0, fill 8 entries:
   - br_ack_o = 0 while br_req_i is held.
   - A single 0x44 read raises br_ack_o the next cycle; the held entry is then accepted as entry 9.
4. Full FIFO, push and 0x44 read in the same cycle:
   - count stays 8, drop_cnt stays 0.
   - Returned data = oldest entry; the new entry is read last.
   - Pointer wrap is exercised over 3 fills.
5. Write 0x4C=1, push one entry:
   - irq_o rises one cycle after the push.
   - Read 0x44 → irq_o falls one cycle later.
   - Read 0x44 on empty → data 0, count stays 0.
6. Assert rst_ni low asynchronously mid-stream with 5 entries buffered:
   - irq_o and cfg_data_o go to 0 immediately.
   - After release, 0x48 reads 0.

Source files
------------

// File: rtl/dmni_br_mailbox.sv
// dmni_br_mailbox: BrLite broadcast FIFO exposed through the DMNI MMR window 0x40-0x4C.
module dmni_br_mailbox #(
    parameter int PAYLOAD_W    = 16,
    parameter int SEQ_W        = 16,
    parameter int KSVC_W       = 4,
    parameter int DEPTH        = 8,
    parameter bit DROP_ON_FULL = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 br_req_i,
    output logic                 br_ack_o,
    input  logic [KSVC_W-1:0]    br_ksvc_i,
    input  logic [SEQ_W-1:0]     br_seq_source_i,
    input  logic [PAYLOAD_W-1:0] br_payload_i,
    input  logic                 cfg_sel_i,
    input  logic                 cfg_we_i,
    input  logic [7:0]           cfg_addr_i,
    input  logic [31:0]          cfg_data_i,
    output logic [31:0]          cfg_data_o,
    output logic                 irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [KSVC_W-1:0]    mem_ksvc    [DEPTH];
    logic [SEQ_W-1:0]     mem_seq     [DEPTH];
    logic [PAYLOAD_W-1:0] mem_payload [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_nxt;
    logic [7:0]           drop_cnt;
    logic                 ovf, irq_en, irq_en_nxt;
    logic                 full, empty, rd, wr, pop, take, push, drop, clr;
    logic [31:0]          rdata;
    logic                 cfg_unused;

    assign cfg_unused = ^cfg_data_i[31:1];
    assign full       = count == CW'(DEPTH);
    assign empty      = count == '0;
    assign br_ack_o   = DROP_ON_FULL ? 1'b1 : ~full;
    assign rd         = cfg_sel_i & ~cfg_we_i;
    assign wr         = cfg_sel_i & cfg_we_i;
    assign pop        = rd & (cfg_addr_i == 8'h44) & ~empty;
    assign take       = br_req_i & br_ack_o;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push       = take & (~full | pop);
    assign drop       = take & full & ~pop;
    assign clr        = wr & (cfg_addr_i == 8'h48);
    assign irq_en_nxt = (wr & (cfg_addr_i == 8'h4C)) ? cfg_data_i[0] : irq_en;
    assign count_nxt  = count + CW'(push) - CW'(pop);

    always_comb begin
        rdata = (cfg_addr_i == 8'h40) ? {empty, 31'(empty ? '0 : mem_ksvc[rd_ptr])} :
                (cfg_addr_i == 8'h44) ? (empty ? '0 : 32'({mem_seq[rd_ptr], mem_payload[rd_ptr]})) :
                (cfg_addr_i == 8'h48) ? {ovf, 7'b0, drop_cnt, 8'b0, 8'(count)} :
                (cfg_addr_i == 8'h4C) ? {31'b0, irq_en} : '0;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_ksvc[wr_ptr]    <= br_ksvc_i;
            mem_seq[wr_ptr]     <= br_seq_source_i;
            mem_payload[wr_ptr] <= br_payload_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_cnt   <= '0;
            ovf        <= 1'b0;
            irq_en     <= 1'b0;
            cfg_data_o <= '0;
            irq_o      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (rd) cfg_data_o <= rdata;
            count    <= count_nxt;
            drop_cnt <= clr ? 8'd0 : (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
            ovf      <= clr ? 1'b0 : ovf | drop;
            irq_en   <= irq_en_nxt;
            irq_o    <= irq_en_nxt & (count_nxt != '0);
        end
    end
endmodule
